unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency backing memory between the pipeline's instruction-fetch port (IF) and data-memory port (MEM).
- Arbitrates between the two ports, sequences each access over a req/ack handshake, and returns read data.
- Drives a stall signal that the hazard logic uses to freeze the PC and the pipeline registers while an access is outstanding.
- Sits between the IF/MEM stages and the memory model.

Parameters:
ADDR_W, 32, address width, byte address
DATA_W, 32, data width
MAX_WAIT, 4, consecutive IF losses before IF is forced to win
TIMEOUT, 64, cycles without ack before abort (ARB_TIMEOUT_EN only)

Ports:
clk_i  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request, held until if_done_o
if_addr_i  in  ADDR_W  fetch address
if_done_o  out  1  one-cycle pulse, fetch complete
if_rdata_o  out  DATA_W  fetched instruction, valid with if_done_o and held until next IF done
dm_req_i  in  1  data request, held until dm_done_o
dm_we_i  in  1  1=store, 0=load
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  store data
dm_done_o  out  1  one-cycle pulse, data access complete
dm_rdata_o  out  DATA_W  load data, valid with dm_done_o and held
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_ack_i  in  1  memory completion; rdata valid same cycle
mem_rdata_i  in  DATA_W  memory read data
stall_o  out  1  pipeline stall
err_o  out  1  one-cycle timeout pulse; constant 0 without macro

Behaviour:
Reset:
- All outputs go to 0 immediately; rdata registers clear to 0.
- FSM goes to IDLE; wait counter clears to 0.
- A reset mid-access drops mem_req_o at once; the transaction is abandoned with no done pulse.

FSM states: IDLE, SRV_IF, SRV_DM.
- IDLE, no request: stay in IDLE.
- IDLE, request present, pick a winner:
  - Priority: dm_req_i over if_req_i.
  - Exception: if wait_cnt == MAX_WAIT and if_req_i=1, IF wins.
- On a grant: latch addr, we and wdata into the mem_* registers; set mem_req_o=1 on the next edge; move to SRV_IF or SRV_DM.
- wait_cnt rules:
  - Increments (saturating at MAX_WAIT) when IF is requesting and DM wins.
  - Clears when IF wins.
  - Unchanged otherwise.
- IF grants always drive mem_we_o=0.
- SRV_x: mem_* outputs stay stable until mem_ack_i.
- SRV_x, on mem_ack_i:
  - Drop mem_req_o.
  - Capture mem_rdata_i into x_rdata_o; for a store, dm_rdata_o is unchanged.
  - Pulse x_done_o for one cycle.
  - Return to IDLE.
- Minimum transaction time: 3 cycles. Request sampled at edge N, mem_req_o high after N, ack in cycle M ≥ N+1, done high in cycle M+1.
- A request still high in the cycle its done pulses must not be re-granted. The requester drops the request in that cycle or it is treated as a new access.
- An ack arriving in IDLE is ignored.
- Arbitration happens only in IDLE. After any completion there is one IDLE cycle (bubble) before the next grant.

stall_o (combinational):
- stall_o = (if_req_i & ~if_done_o) | (dm_req_i & ~dm_done_o).
- Deasserts in the done cycle so the pipeline advances exactly once.

Optional Feature:
ARB_TIMEOUT_EN
- With the macro:
  - A TIMEOUT-wide counter runs in SRV_x and clears on entry to SRV_x.
  - If it reaches TIMEOUT-1 with no ack: drop mem_req_o, pulse x_done_o and err_o together, leave x_rdata_o unchanged, return to IDLE.
  - An ack in the same cycle as the timeout wins: normal completion, no err_o.
- Without the macro: no counter; err_o is tied to 0; the FSM waits indefinitely for ack.

Decomposition:
- Shared package: the FSM state enum (IDLE/SRV_IF/SRV_DM), port-select constants, default widths.
- One sub-module, arb_priority_sel: combinational winner select plus wait_cnt saturating counter.
- The FSM and datapath registers stay in the top module.

Test Plan:
- IF only, addr 0x10, ack 2 cycles after mem_req_o, rdata 0x2002000A -> mem_addr_o=0x10, mem_we_o=0; if_done_o pulses once; if_rdata_o=0x2002000A; stall_o high until the done cycle.
- IF and DM requesting in the same cycle (DM load from 0x40) -> DM served first, then a 1-cycle bubble, then IF; dm_done_o precedes if_done_o.
- Back-to-back DM stores, MAX_WAIT=4, IF requesting throughout -> DM wins 4 times; the 5th grant goes to IF even though DM is requesting; wait_cnt returns to 0.
- DM store addr 0x8, wdata 0xDEADBEEF, ack after 1 cycle -> mem_we_o=1 and mem_wdata_o held until ack; dm_rdata_o unchanged.
- rst_n asserted while in SRV_DM -> mem_req_o=0 and all outputs 0 immediately; no done pulse; a fresh IF after reset is granted normally.
- With ARB_TIMEOUT_EN and TIMEOUT=8, no ack -> done and err_o pulse together 8 cycles after mem_req_o rises; then repeat with ack in that same cycle -> done without err_o.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and default widths for the unified IF/MEM memory arbiter.
package unified_mem_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned MAX_WAIT_DEF = 4;
  localparam int unsigned TIMEOUT_DEF  = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SRV_IF = 2'd1,
    ST_SRV_DM = 2'd2
  } state_e;

  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_DM = 1'b1
  } port_sel_e;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, data and backing-memory signals of the arbiter; slave = arbiter side.
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_done_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_done_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o;
  logic              err_o;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    output if_done_o, if_rdata_o, dm_done_o, dm_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  if_done_o, if_rdata_o, dm_done_o, dm_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o
  );
endinterface

// File: rtl/unified_mem_arbiter_arb_priority_sel.sv
// Winner select (DM first unless IF has lost MAX_WAIT times in a row) and
// the saturating IF-loss counter, updated only on an actual grant.
module unified_mem_arbiter_arb_priority_sel
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic      clk_i,
  input  logic      rst_n,
  input  logic      arb_en_i,
  input  logic      if_req_i,
  input  logic      dm_req_i,
  output logic      grant_c,
  output port_sel_e sel_c
);

  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             force_if;

  always_comb begin
    grant_c    = arb_en_i & (if_req_i | dm_req_i);
    force_if   = if_req_i & (wait_cnt_q == CNT_W'(MAX_WAIT));
    sel_c      = (dm_req_i & ~force_if) ? SEL_DM : SEL_IF;
    wait_cnt_d = wait_cnt_q;
    if (grant_c) begin
      if (sel_c == SEL_IF) begin
        wait_cnt_d = '0;
      end else if (if_req_i && (wait_cnt_q != CNT_W'(MAX_WAIT))) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one variable-latency memory between fetch and data ports.
// Optional ARB_TIMEOUT_EN: abort an access after TIMEOUT cycles without ack.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
`ifdef ARB_TIMEOUT_EN
 ,parameter int unsigned TIMEOUT  = TIMEOUT_DEF
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  unified_mem_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_done_q, if_done_d;
  logic              dm_done_q, dm_done_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              arb_en;
  logic              grant_c;
  port_sel_e         sel_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
`endif

  // No grant while a done pulses: the finishing requester may still hold req.
  assign arb_en = (state_q == ST_IDLE) & ~if_done_q & ~dm_done_q;

  unified_mem_arbiter_arb_priority_sel #(.MAX_WAIT(MAX_WAIT)) u_sel (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .arb_en_i (arb_en),
    .if_req_i (bus.if_req_i),
    .dm_req_i (bus.dm_req_i),
    .grant_c  (grant_c),
    .sel_c    (sel_c)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
          mem_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
          if (sel_c == SEL_DM) begin
            mem_we_d    = bus.dm_we_i;
            mem_addr_d  = bus.dm_addr_i;
            mem_wdata_d = bus.dm_wdata_i;
            state_d     = ST_SRV_DM;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr_i;
            state_d     = ST_SRV_IF;
          end
        end
      end
      ST_SRV_IF, ST_SRV_DM: begin
        if (bus.mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (state_q == ST_SRV_IF) begin
            if_done_d  = 1'b1;
            if_rdata_d = bus.mem_rdata_i;
          end else begin
            dm_done_d  = 1'b1;
            if (!mem_we_q) dm_rdata_d = bus.mem_rdata_i;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // Abort keeps the rdata register; requester sees done with err.
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          err_d     = 1'b1;
          if (state_q == ST_SRV_IF) if_done_d = 1'b1;
          else                      dm_done_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.dm_done_o   = dm_done_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;
  // Drops in the done cycle so the pipeline advances exactly once.
  assign bus.stall_o     = (bus.if_req_i & ~if_done_q) | (bus.dm_req_i & ~dm_done_q);
`ifdef ARB_TIMEOUT_EN
  assign bus.err_o       = err_q;
`else
  assign bus.err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter; timeout steps run only with ARB_TIMEOUT_EN.
module tb_unified_mem_arbiter;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  unified_mem_arbiter_if bus ();

  unified_mem_arbiter #(
    .MAX_WAIT(4)
`ifdef ARB_TIMEOUT_EN
   ,.TIMEOUT(8)
`endif
  ) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req_i = 0; bus.if_addr_i = '0;
    bus.dm_req_i = 0; bus.dm_we_i = 0; bus.dm_addr_i = '0; bus.dm_wdata_i = '0;
    bus.mem_ack_i = 0; bus.mem_rdata_i = '0;
    #3;
    check("rst_mem_req", bus.mem_req_o, 0);
    check("rst_if_done", bus.if_done_o, 0);
    check("rst_dm_done", bus.dm_done_o, 0);
    check("rst_if_rdata", bus.if_rdata_o, 0);
    check("rst_dm_rdata", bus.dm_rdata_o, 0);
    check("rst_stall", bus.stall_o, 0);
    check("rst_err", bus.err_o, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    // IF-only fetch, ack two cycles after mem_req rises
    bus.if_req_i = 1; bus.if_addr_i = 32'h10; #1;
    check("t1_stall_pre", bus.stall_o, 1);
    check("t1_req_pre", bus.mem_req_o, 0);
    tick(); #1;
    check("t1_mem_req", bus.mem_req_o, 1);
    check("t1_mem_addr", bus.mem_addr_o, 32'h10);
    check("t1_mem_we", bus.mem_we_o, 0);
    tick(); #1;
    check("t1_req_hold", bus.mem_req_o, 1);
    check("t1_no_done", bus.if_done_o, 0);
    tick(); bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h2002000A; #1;
    check("t1_done_ack_cyc", bus.if_done_o, 0);
    check("t1_stall_ack_cyc", bus.stall_o, 1);
    tick(); bus.mem_ack_i = 0; #1;
    check("t1_done", bus.if_done_o, 1);
    check("t1_rdata", bus.if_rdata_o, 32'h2002000A);
    check("t1_req_drop", bus.mem_req_o, 0);
    check("t1_stall_done", bus.stall_o, 0);
    bus.if_req_i = 0;
    tick(); #1;
    check("t1_done_once", bus.if_done_o, 0);
    check("t1_no_regrant", bus.mem_req_o, 0);
    check("t1_rdata_held", bus.if_rdata_o, 32'h2002000A);

    // Simultaneous IF and DM load: DM first, bubble, then IF
    bus.if_req_i = 1; bus.if_addr_i = 32'h20;
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h40; #1;
    check("t2_stall", bus.stall_o, 1);
    tick(); #1;
    check("t2_dm_req", bus.mem_req_o, 1);
    check("t2_dm_addr", bus.mem_addr_o, 32'h40);
    check("t2_dm_we", bus.mem_we_o, 0);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h11112222;
    tick(); bus.mem_ack_i = 0; #1;
    check("t2_dm_done", bus.dm_done_o, 1);
    check("t2_dm_rdata", bus.dm_rdata_o, 32'h11112222);
    check("t2_if_not_done", bus.if_done_o, 0);
    check("t2_stall_if", bus.stall_o, 1);
    bus.dm_req_i = 0;
    tick(); #1;
    check("t2_bubble", bus.mem_req_o, 0);
    tick(); #1;
    check("t2_if_req", bus.mem_req_o, 1);
    check("t2_if_addr", bus.mem_addr_o, 32'h20);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h33334444;
    tick(); bus.mem_ack_i = 0; #1;
    check("t2_if_done", bus.if_done_o, 1);
    check("t2_if_rdata", bus.if_rdata_o, 32'h33334444);
    check("t2_dm_rdata_held", bus.dm_rdata_o, 32'h11112222);
    bus.if_req_i = 0;
    tick();

    // DM stores back-to-back with IF waiting: IF forced in on the 5th grant
    bus.if_req_i = 1; bus.if_addr_i = 32'h100;
    bus.dm_req_i = 1; bus.dm_we_i = 1; bus.dm_addr_i = 32'h200; bus.dm_wdata_i = 32'hA0000000;
    tick(); #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_dm_req", bus.mem_req_o, 1);
      check("t3_dm_we", bus.mem_we_o, 1);
      check("t3_dm_addr", bus.mem_addr_o, 32'h200 + 32'(4 * i));
      check("t3_dm_wdata", bus.mem_wdata_o, 32'hA0000000 + 32'(i));
      bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hBAD0BAD0;
      tick(); bus.mem_ack_i = 0; #1;
      check("t3_dm_done", bus.dm_done_o, 1);
      check("t3_store_rdata", bus.dm_rdata_o, 32'h11112222);
      if (i < 3) begin
        bus.dm_addr_i = 32'h200 + 32'(4 * (i + 1)); bus.dm_wdata_i = 32'hA0000000 + 32'(i + 1);
      end else begin
        bus.dm_addr_i = 32'h8; bus.dm_wdata_i = 32'hDEADBEEF;
      end
      tick(); #1;
      check("t3_bubble", bus.mem_req_o, 0);
      tick(); #1;
    end
    check("t3_if_forced_req", bus.mem_req_o, 1);
    check("t3_if_forced_we", bus.mem_we_o, 0);
    check("t3_if_forced_addr", bus.mem_addr_o, 32'h100);
    check("t3_wait_cnt_clr", 64'(dut.u_sel.wait_cnt_q), 0);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h55556666;
    tick(); bus.mem_ack_i = 0; #1;
    check("t3_if_done", bus.if_done_o, 1);
    check("t3_if_rdata", bus.if_rdata_o, 32'h55556666);
    check("t3_dm_not_done", bus.dm_done_o, 0);
    bus.if_req_i = 0;
    tick(); #1;
    check("t3_bubble2", bus.mem_req_o, 0);

    // DM store to 0x8, ack one cycle after mem_req rises
    tick(); #1;
    check("t4_req", bus.mem_req_o, 1);
    check("t4_we", bus.mem_we_o, 1);
    check("t4_addr", bus.mem_addr_o, 32'h8);
    check("t4_wdata", bus.mem_wdata_o, 32'hDEADBEEF);
    tick(); #1;
    check("t4_req_hold", bus.mem_req_o, 1);
    check("t4_we_hold", bus.mem_we_o, 1);
    check("t4_wdata_hold", bus.mem_wdata_o, 32'hDEADBEEF);
    check("t4_no_done", bus.dm_done_o, 0);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'hBAD0BAD0;
    tick(); bus.mem_ack_i = 0; #1;
    check("t4_done", bus.dm_done_o, 1);
    check("t4_rdata_kept", bus.dm_rdata_o, 32'h11112222);
    check("t4_req_drop", bus.mem_req_o, 0);
    bus.dm_req_i = 0;
    tick();

    // Reset while a DM load is outstanding
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h44;
    tick(); #1;
    check("t5_req", bus.mem_req_o, 1);
    check("t5_addr", bus.mem_addr_o, 32'h44);
    tick(); #2;
    rst_n = 0; bus.dm_req_i = 0; #1;
    check("t5_rst_req", bus.mem_req_o, 0);
    check("t5_rst_addr", bus.mem_addr_o, 0);
    check("t5_rst_dm_done", bus.dm_done_o, 0);
    check("t5_rst_if_rdata", bus.if_rdata_o, 0);
    check("t5_rst_dm_rdata", bus.dm_rdata_o, 0);
    check("t5_rst_stall", bus.stall_o, 0);
    tick(); tick();
    rst_n = 1; #1;
    check("t5_post_no_done", bus.dm_done_o, 0);
    bus.if_req_i = 1; bus.if_addr_i = 32'h30;
    tick(); #1;
    check("t5_if_req", bus.mem_req_o, 1);
    check("t5_if_addr", bus.mem_addr_o, 32'h30);
    bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h77;
    tick(); bus.mem_ack_i = 0; #1;
    check("t5_if_done", bus.if_done_o, 1);
    check("t5_if_rdata", bus.if_rdata_o, 32'h77);
    check("t5_dm_done_quiet", bus.dm_done_o, 0);
    bus.if_req_i = 0;
    tick();

`ifdef ARB_TIMEOUT_EN
    // No ack: done and err together eight cycles after mem_req rises
    bus.dm_req_i = 1; bus.dm_we_i = 0; bus.dm_addr_i = 32'h60;
    tick(); #1;
    check("t6_req", bus.mem_req_o, 1);
    for (int k = 1; k < 8; k++) begin
      tick(); #1;
      check("t6_wait_done", bus.dm_done_o, 0);
      check("t6_wait_err", bus.err_o, 0);
      check("t6_wait_req", bus.mem_req_o, 1);
    end
    tick(); #1;
    check("t6_to_done", bus.dm_done_o, 1);
    check("t6_to_err", bus.err_o, 1);
    check("t6_to_req", bus.mem_req_o, 0);
    check("t6_to_rdata", bus.dm_rdata_o, 0);
    bus.dm_req_i = 0;
    tick(); #1;
    check("t6_err_pulse", bus.err_o, 0);

    // Ack in the timeout cycle wins
    bus.dm_req_i = 1; bus.dm_addr_i = 32'h64;
    tick(); #1;
    check("t7_req", bus.mem_req_o, 1);
    for (int k = 1; k < 7; k++) begin
      tick(); #1;
      check("t7_wait_done", bus.dm_done_o, 0);
    end
    tick(); bus.mem_ack_i = 1; bus.mem_rdata_i = 32'h99;
    tick(); bus.mem_ack_i = 0; #1;
    check("t7_done", bus.dm_done_o, 1);
    check("t7_no_err", bus.err_o, 0);
    check("t7_rdata", bus.dm_rdata_o, 32'h99);
    bus.dm_req_i = 0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
